cond_flag_unit: RTL and testbench

- Sits directly downstream of the ALU in the single-cycle/pipelined ARM-subset datapath.
- Consumes the ALU's 4-bit NZCV flags and holds them in the architectural status register.
- Evaluates each instruction's 4-bit condition field and gates PCSrc/RegWrite/MemWrite.
- Presents the result through one registered valid/ready output stage, and keeps saturating executed/skipped counters for debug.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/cond_check.sv | 40 ++++
 rtl/cond_flag_unit.sv | 116 +++++++++++
 tb/tb_cond_flag_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/condition definitions: condition codes, flag bit positions, ALU controls.
package alu_pkg;

    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAGS_W = 4;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // ARM condition field encoding
    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // ALU operation select, shared with the ALU
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_EOR = 3'd4,
        ALU_MOV = 3'd5
    } alu_ctrl_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: (cond, flags) -> condition passed.
module cond_check
    import alu_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               ce
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode condition field against NZCV; reserved code never passes
    always_comb begin
        ce = 1'b0;
        case (cond_e'(cond))
            COND_EQ: ce = z;
            COND_NE: ce = !z;
            COND_CS: ce = c;
            COND_CC: ce = !c;
            COND_MI: ce = n;
            COND_PL: ce = !n;
            COND_VS: ce = v;
            COND_VC: ce = !v;
            COND_HI: ce = c && !z;
            COND_LS: ce = !c || z;
            COND_GE: ce = (n == v);
            COND_LT: ce = (n != v);
            COND_GT: ce = !z && (n == v);
            COND_LE: ce = z || (n != v);
            COND_AL: ce = 1'b1;
            default: ce = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Status register, condition gating of write enables, registered output stage
// and saturating executed/skipped statistics.
module cond_flag_unit
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic [1:0]         flag_w,
    input  logic               pcs,
    input  logic               reg_w,
    input  logic               mem_w,
    input  logic               no_write,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               pc_src,
    output logic               reg_write,
    output logic               mem_write,
    output logic               cond_ex,
    output logic [FLAGS_W-1:0] flags,
    output logic [CNT_W-1:0]   exec_count,
    output logic [CNT_W-1:0]   skip_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               ce_c;
    logic               accept_c;
    logic               out_valid_nxt;
    logic               pc_src_nxt;
    logic               reg_write_nxt;
    logic               mem_write_nxt;
    logic               cond_ex_nxt;
    logic [FLAGS_W-1:0] flags_nxt;
    logic [CNT_W-1:0]   exec_nxt;
    logic [CNT_W-1:0]   skip_nxt;

    // Condition is checked against the flags as they stand before this instruction
    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags),
        .ce    (ce_c)
    );

    // Output stage can take a new result when empty or being drained
    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Next-state: load on accept, drain on out_ready, otherwise hold
    always_comb begin
        out_valid_nxt = out_valid;
        pc_src_nxt    = pc_src;
        reg_write_nxt = reg_write;
        mem_write_nxt = mem_write;
        cond_ex_nxt   = cond_ex;
        flags_nxt     = flags;
        exec_nxt      = exec_count;
        skip_nxt      = skip_count;

        if (accept_c) begin
            out_valid_nxt = 1'b1;
            pc_src_nxt    = pcs && ce_c;
            reg_write_nxt = reg_w && ce_c && !no_write;
            mem_write_nxt = mem_w && ce_c;
            cond_ex_nxt   = ce_c;
            if (flag_w[1] && ce_c) begin
                flags_nxt[FLAG_N] = alu_flags[FLAG_N];
                flags_nxt[FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (flag_w[0] && ce_c) begin
                flags_nxt[FLAG_C] = alu_flags[FLAG_C];
                flags_nxt[FLAG_V] = alu_flags[FLAG_V];
            end
            if (ce_c) begin
                if (exec_count != CNT_MAX) begin
                    exec_nxt = exec_count + CNT_W'(1);
                end
            end else begin
                if (skip_count != CNT_MAX) begin
                    skip_nxt = skip_count + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    // State register; reset drops any held result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            pc_src     <= 1'b0;
            reg_write  <= 1'b0;
            mem_write  <= 1'b0;
            cond_ex    <= 1'b0;
            flags      <= '0;
            exec_count <= '0;
            skip_count <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            pc_src     <= pc_src_nxt;
            reg_write  <= reg_write_nxt;
            mem_write  <= mem_write_nxt;
            cond_ex    <= cond_ex_nxt;
            flags      <= flags_nxt;
            exec_count <= exec_nxt;
            skip_count <= skip_nxt;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed vector bench for cond_flag_unit (counters built 4 bits wide).
module tb_cond_flag_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs;
    logic             reg_w;
    logic             mem_w;
    logic             no_write;
    logic             out_valid;
    logic             out_ready;
    logic             pc_src;
    logic             reg_write;
    logic             mem_write;
    logic             cond_ex;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    int checks;
    int errors;

    cond_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cond       (cond),
        .alu_flags  (alu_flags),
        .flag_w     (flag_w),
        .pcs        (pcs),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .no_write   (no_write),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .cond_ex    (cond_ex),
        .flags      (flags),
        .exec_count (exec_count),
        .skip_count (skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] alu;
        logic       pcs;
        logic       rw;
        logic       mw;
        logic       nw;
        logic       e_ce;
        logic       e_pc;
        logic       e_rw;
        logic       e_mw;
        logic [3:0] e_flags;
        int         e_exec;
        int         e_skip;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                                input logic p, input logic rw, input logic mw, input logic nw,
                                input logic ece, input logic epc, input logic erw, input logic emw,
                                input logic [3:0] ef, input int ex, input int sk);
        vec_t r;
        r.cond = c; r.fw = fw; r.alu = alu; r.pcs = p; r.rw = rw; r.mw = mw; r.nw = nw;
        r.e_ce = ece; r.e_pc = epc; r.e_rw = erw; r.e_mw = emw;
        r.e_flags = ef; r.e_exec = ex; r.e_skip = sk;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                         input logic p, input logic rw, input logic mw, input logic nw);
        in_valid = 1'b1; cond = c; flag_w = fw; alu_flags = alu;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    endtask

    task automatic idle();
        in_valid = 1'b0; cond = 4'b0000; flag_w = 2'b00; alu_flags = 4'b0000;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        out_ready = 1'b1;
        idle();

        //                cond     fw     alu     p  rw mw nw  ce pc rw mw flags  ex sk
        vecs[0]  = mk(4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1);
        vecs[1]  = mk(4'b1110, 2'b11, 4'b0100, 0, 1, 0, 0, 1, 0, 1, 0, 4'b0100, 1, 1);
        vecs[2]  = mk(4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 1, 0, 1, 0, 4'b0100, 2, 1);
        vecs[3]  = mk(4'b0001, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0100, 2, 2);
        vecs[4]  = mk(4'b1110, 2'b01, 4'b1011, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0111, 3, 2);
        vecs[5]  = mk(4'b1010, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0111, 3, 3);
        vecs[6]  = mk(4'b1011, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0111, 4, 3);
        vecs[7]  = mk(4'b1111, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0111, 4, 4);
        vecs[8]  = mk(4'b1110, 2'b00, 4'b0000, 0, 1, 0, 1, 1, 0, 0, 0, 4'b0111, 5, 4);
        vecs[9]  = mk(4'b1000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0111, 5, 5);
        vecs[10] = mk(4'b1001, 2'b00, 4'b0000, 1, 0, 0, 0, 1, 1, 0, 0, 4'b0111, 6, 5);
        vecs[11] = mk(4'b1100, 2'b11, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0111, 6, 6);
        vecs[12] = mk(4'b1101, 2'b10, 4'b1000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1011, 7, 6);
        vecs[13] = mk(4'b0100, 2'b00, 4'b0000, 0, 0, 1, 0, 1, 0, 0, 1, 4'b1011, 8, 6);
        vecs[14] = mk(4'b0101, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1011, 8, 7);
        vecs[15] = mk(4'b0010, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1011, 9, 7);
        vecs[16] = mk(4'b0011, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1011, 9, 8);
        vecs[17] = mk(4'b0110, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1011, 10, 8);
        vecs[18] = mk(4'b0111, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1011, 10, 9);
        vecs[19] = mk(4'b1100, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1011, 11, 9);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_flags", int'(flags), 0);
        chk("reset_cond_ex", int'(cond_ex), 0);
        chk("reset_reg_write", int'(reg_write), 0);
        chk("reset_exec", int'(exec_count), 0);
        chk("reset_skip", int'(skip_count), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        reset_n = 1'b1;

        // Back-to-back accepts with out_ready held high
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].cond, vecs[i].fw, vecs[i].alu, vecs[i].pcs, vecs[i].rw, vecs[i].mw, vecs[i].nw);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("v%0d_cond_ex", i), int'(cond_ex), int'(vecs[i].e_ce));
            chk($sformatf("v%0d_pc_src", i), int'(pc_src), int'(vecs[i].e_pc));
            chk($sformatf("v%0d_reg_write", i), int'(reg_write), int'(vecs[i].e_rw));
            chk($sformatf("v%0d_mem_write", i), int'(mem_write), int'(vecs[i].e_mw));
            chk($sformatf("v%0d_flags", i), int'(flags), int'(vecs[i].e_flags));
            chk($sformatf("v%0d_exec", i), int'(exec_count), vecs[i].e_exec);
            chk($sformatf("v%0d_skip", i), int'(skip_count), vecs[i].e_skip);
        end

        // Backpressure: pending instruction would clear flags if it slipped through
        drive(4'b1110, 2'b11, 4'b0000, 0, 1, 0, 0);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready_comb", int'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", i), int'(in_ready), 0);
            chk($sformatf("bp%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("bp%0d_cond_ex", i), int'(cond_ex), 1);
            chk($sformatf("bp%0d_reg_write", i), int'(reg_write), 0);
            chk($sformatf("bp%0d_flags", i), int'(flags), 4'b1011);
            chk($sformatf("bp%0d_exec", i), int'(exec_count), 11);
            chk($sformatf("bp%0d_skip", i), int'(skip_count), 9);
        end
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("rel_out_valid", int'(out_valid), 1);
        chk("rel_reg_write", int'(reg_write), 1);
        chk("rel_flags", int'(flags), 0);
        chk("rel_exec", int'(exec_count), 12);
        idle();
        @(negedge clk);
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_exec", int'(exec_count), 12);
        chk("drain_skip", int'(skip_count), 9);
        @(negedge clk);
        chk("idle_flags", int'(flags), 0);
        chk("idle_exec", int'(exec_count), 12);

        // Fresh reset, then saturate exec_count
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst2_exec", int'(exec_count), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(4'b1110, 2'b11, 4'b1010, 0, 1, 0, 0);
            @(negedge clk);
            chk($sformatf("sat%0d_exec", i), int'(exec_count), (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_skip", int'(skip_count), 0);
        chk("sat_flags", int'(flags), 4'b1010);
        chk("sat_out_valid", int'(out_valid), 1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_flags", int'(flags), 0);
        chk("async_exec", int'(exec_count), 0);
        chk("async_skip", int'(skip_count), 0);
        chk("async_reg_write", int'(reg_write), 0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
